// File: rtl/sr_pkg.sv
// ---------------------------------------------------------------------------
// sr_pkg
// Shared definitions for the clocked set/reset flag register.
//   conflict_mode_e : per-bit action when set and reset are both requested
//   to_mode()       : maps an integer mode parameter onto conflict_mode_e,
//                     folding unknown values onto CM_HOLD
// ---------------------------------------------------------------------------
package sr_pkg;

  typedef enum logic [1:0] {
    CM_HOLD   = 2'd0,
    CM_SET    = 2'd1,
    CM_RESET  = 2'd2,
    CM_TOGGLE = 2'd3
  } conflict_mode_e;

  // Anything outside the four defined encodings behaves as hold.
  function automatic conflict_mode_e to_mode(input int mode);
    case (mode)
      1:       return CM_SET;
      2:       return CM_RESET;
      3:       return CM_TOGGLE;
      default: return CM_HOLD;
    endcase
  endfunction

endpackage : sr_pkg

// File: rtl/sr_bit.sv
// ---------------------------------------------------------------------------
// sr_bit
// One clocked SR storage bit with a registered conflict flag.
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset
//   s_i, r_i   : set / reset requests, sampled on the rising edge
//   q_o        : stored state
//   conflict_o : high for one cycle after an edge that sampled s_i=r_i=1
// ---------------------------------------------------------------------------
module sr_bit
  import sr_pkg::*;
#(
  parameter conflict_mode_e MODE      = CM_HOLD,
  parameter logic           RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic s_i,
  input  logic r_i,
  output logic q_o,
  output logic conflict_o
);

  logic state_q, state_d;
  logic conflict_q, conflict_d;

  // NOTE: every output of this block is assigned a default first, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    conflict_d = s_i & r_i;
    case ({s_i, r_i})
      2'b10: state_d = 1'b1;
      2'b01: state_d = 1'b0;
      2'b11: begin
        case (MODE)
          CM_SET:    state_d = 1'b1;
          CM_RESET:  state_d = 1'b0;
          CM_TOGGLE: state_d = ~state_q;
          default:   state_d = state_q;
        endcase
      end
      default: state_d = state_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update
  // together at the edge regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= RESET_BIT;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      conflict_q <= conflict_d;
    end
  end

  assign q_o        = state_q;
  assign conflict_o = conflict_q;

endmodule : sr_bit

// File: rtl/clocked_sr_latch.sv
// ---------------------------------------------------------------------------
// clocked_sr_latch
// Vector of independent clocked SR flag bits.
//   clk          : rising-edge clock
//   reset        : asynchronous active-high reset (q <= RESET_VALUE)
//   s, r         : per-bit set / reset requests
//   q            : stored state
//   q_n          : ~q, combinational from q (so it tracks reset immediately)
//   conflict     : per-bit registered flag for a sampled s=r=1
//   conflict_any : OR of conflict
// CONFLICT_MODE: 0 hold, 1 set, 2 reset, 3 toggle; other values act as 0.
// ---------------------------------------------------------------------------
module clocked_sr_latch
  import sr_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               CONFLICT_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] conflict,
  output logic             conflict_any
);

  localparam conflict_mode_e MODE = to_mode(CONFLICT_MODE);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_bit #(
      .MODE      (MODE),
      .RESET_BIT (RESET_VALUE[i])
    ) u_bit (
      .clk        (clk),
      .reset      (reset),
      .s_i        (s[i]),
      .r_i        (r[i]),
      .q_o        (q[i]),
      .conflict_o (conflict[i])
    );
  end

  assign q_n          = ~q;
  assign conflict_any = |conflict;

endmodule : clocked_sr_latch

// File: tb/tb_clocked_sr_latch.sv
// ---------------------------------------------------------------------------
// tb_clocked_sr_latch
// Five 4-bit instances share one stimulus stream, one per conflict mode
// (0,1,2,3) plus an out-of-range mode (5) with a non-zero reset value.
// A reference model per instance predicts q and conflict from the SR rules.
// ---------------------------------------------------------------------------
module tb_clocked_sr_latch;

  localparam int N = 5;
  localparam int MODE_TAB [N] = '{0, 1, 2, 3, 5};
  localparam logic [3:0] RV_TAB [N] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0110};

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] s, r;
  logic [3:0] q_w   [N];
  logic [3:0] qn_w  [N];
  logic [3:0] c_w   [N];
  logic       ca_w  [N];

  logic [3:0] mq [N];
  logic [3:0] mc [N];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    clocked_sr_latch #(
      .WIDTH         (4),
      .CONFLICT_MODE (MODE_TAB[g]),
      .RESET_VALUE   (RV_TAB[g])
    ) dut (
      .clk          (clk),
      .reset        (reset),
      .s            (s),
      .r            (r),
      .q            (q_w[g]),
      .q_n          (qn_w[g]),
      .conflict     (c_w[g]),
      .conflict_any (ca_w[g])
    );
  end

  task automatic check(input string tag, input int inst,
                       input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s[%0d]: observed %b expected %b", tag, inst, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < N; i++) begin
      check({tag, ".q"},    i, q_w[i],  mq[i]);
      check({tag, ".q_n"},  i, qn_w[i], ~mq[i]);
      check({tag, ".conf"}, i, c_w[i],  mc[i]);
      check({tag, ".any"},  i, {3'b000, ca_w[i]}, {3'b000, |mc[i]});
    end
  endtask

  // Reference: conflict bits follow the mode; other bits set, clear or hold.
  task automatic model_edge(input logic [3:0] sv, input logic [3:0] rv);
    logic [3:0] both, plain, cval;
    int m;
    both = sv & rv;
    for (int i = 0; i < N; i++) begin
      m = (MODE_TAB[i] > 3) ? 0 : MODE_TAB[i];
      plain = (mq[i] | (sv & ~rv)) & ~(rv & ~sv);
      case (m)
        1:       cval = 4'b1111;
        2:       cval = 4'b0000;
        3:       cval = ~mq[i];
        default: cval = mq[i];
      endcase
      mq[i] = (plain & ~both) | (cval & both);
      mc[i] = both;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i] = RV_TAB[i];
      mc[i] = 4'b0000;
    end
  endtask

  task automatic step(input logic [3:0] sv, input logic [3:0] rv, input string tag);
    @(negedge clk);
    s = sv;
    r = rv;
    @(posedge clk);
    #1;
    model_edge(sv, rv);
    check_all(tag);
  endtask

  // Reset pulse strictly between edges; outputs checked before the next edge.
  task automatic reset_pulse(input string tag);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    s     = 4'b0001;
    r     = 4'b0000;
    model_reset();
    // Pending set while reset is high, across a clock edge.
    #12;
    check_all("reset_hold");
    @(negedge clk);
    reset = 1'b0;
    step(4'b0001, 4'b0000, "first_edge");
    step(4'b0000, 4'b0000, "hold1");
    step(4'b0000, 4'b0000, "hold2");
    step(4'b0000, 4'b0001, "rst_req");
    step(4'b0001, 4'b0001, "conf_m0");
    step(4'b0000, 4'b0000, "conf_clr");
    step(4'b0101, 4'b1010, "load_0101");
    step(4'b1111, 4'b1111, "conf_modes");
    step(4'b1111, 4'b0000, "load_1111");
    step(4'b1111, 4'b1111, "conf_again");
    reset_pulse("async_mid");
    step(4'b0000, 4'b0000, "post_reset");

    for (int k = 0; k < 300; k++) begin
      step(4'($urandom), 4'($urandom), "rand");
      if ($urandom_range(0, 19) == 0) reset_pulse("rand_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout: observed no finish, expected finish before 100000");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_clocked_sr_latch
